// File: rtl/bus_bridge_demux_if.sv
// CPU-side and target-side signal bundle for the data-bus bridge.
// slave  : the bridge itself (consumes CPU requests and target responses)
// master : the environment driving CPU requests and modelling the targets
interface bus_bridge_demux_if;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [3:0]   cpu_be;
  logic         cpu_busy;
  logic         cpu_ack;
  logic [31:0]  cpu_rdata;
  logic         cpu_err;

  logic [3:0]   tgt_sel;
  logic         tgt_we;
  logic [31:0]  tgt_addr;
  logic [31:0]  tgt_wdata;
  logic [3:0]   tgt_be;
  logic [3:0]   tgt_ack;
  logic [127:0] tgt_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_busy, cpu_ack, cpu_rdata, cpu_err,
    output tgt_sel, tgt_we, tgt_addr, tgt_wdata, tgt_be,
    input  tgt_ack, tgt_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_busy, cpu_ack, cpu_rdata, cpu_err,
    input  tgt_sel, tgt_we, tgt_addr, tgt_wdata, tgt_be,
    output tgt_ack, tgt_rdata
  );
endinterface

// File: rtl/bus_bridge_demux.sv
// Data-bus bridge: decodes one CPU access to one of four targets (DM, TC0,
// TC1, INT regs), waits for that target's ack or a timeout, and returns the
// selected target's read data. One access in flight at a time.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  IDLE    | waiting for cpu_req; decode happens on the accepting edge
//  REQ     | tgt_sel asserted, waiting for selected ack or timeout
//  RESP    | cpu_ack high for this single cycle, rdata/err valid
module bus_bridge_demux #(
  parameter logic [31:0] T0_BASE = 32'h0000_0000,
  parameter logic [31:0] T0_LAST = 32'h0000_2FFF,
  parameter logic [31:0] T1_BASE = 32'h0000_7F00,
  parameter logic [31:0] T1_LAST = 32'h0000_7F0B,
  parameter logic [31:0] T2_BASE = 32'h0000_7F10,
  parameter logic [31:0] T2_LAST = 32'h0000_7F1B,
  parameter logic [31:0] T3_BASE = 32'h0000_7F20,
  parameter logic [31:0] T3_LAST = 32'h0000_7F23,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  bus_bridge_demux_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [3:0]       sel_q,   sel_d;
  logic             we_q,    we_d;
  logic [31:0]      addr_q,  addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q,    be_d;
  logic             ack_q,   ack_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q,   err_d;
  logic             busy_q,  busy_d;

  logic [3:0]  in_range;
  logic [3:0]  hit_sel;
  logic        hit;
  logic        sel_ack;
  logic        timed_out;
  logic [31:0] rd_slice;

  // Address decode; offset-from-base compare keeps each range check to one
  // unsigned comparison, and the if-chain gives the lowest index priority.
  always_comb begin
    in_range[0] = (bus.cpu_addr - T0_BASE) <= (T0_LAST - T0_BASE);
    in_range[1] = (bus.cpu_addr - T1_BASE) <= (T1_LAST - T1_BASE);
    in_range[2] = (bus.cpu_addr - T2_BASE) <= (T2_LAST - T2_BASE);
    in_range[3] = (bus.cpu_addr - T3_BASE) <= (T3_LAST - T3_BASE);
    hit_sel = 4'b0000;
    if (bus.cpu_addr[1:0] == 2'b00) begin
      if (in_range[0])      hit_sel = 4'b0001;
      else if (in_range[1]) hit_sel = 4'b0010;
      else if (in_range[2]) hit_sel = 4'b0100;
      else if (in_range[3]) hit_sel = 4'b1000;
    end
  end

  assign hit       = |hit_sel;
  assign sel_ack   = |(bus.tgt_ack & sel_q);
  assign timed_out = (cnt_q == CNT_LAST);

  // Read-return mux driven by the latched one-hot select.
  always_comb begin
    rd_slice = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (sel_q[i]) rd_slice = rd_slice | bus.tgt_rdata[32*i +: 32];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.cpu_req) state_d = hit ? ST_REQ : ST_RESP;
      ST_REQ:  if (sel_ack || timed_out) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; an ack on the selected target beats a
  // simultaneous timeout because it is tested first.
  always_comb begin
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    busy_d  = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          be_d    = bus.cpu_we ? bus.cpu_be : 4'b0000;
          cnt_d   = '0;
          if (hit) begin
            sel_d = hit_sel;
          end else begin
            rdata_d = 32'h0;
            err_d   = 1'b1;
            ack_d   = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (sel_ack) begin
          rdata_d = we_q ? 32'h0 : rd_slice;
          err_d   = 1'b0;
          sel_d   = 4'b0000;
          ack_d   = 1'b1;
        end else if (timed_out) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          sel_d   = 4'b0000;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and latched access fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      sel_q   <= 4'b0000;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'b0000;
      ack_q   <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.cpu_busy  = busy_q;
  assign bus.cpu_ack   = ack_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_err   = err_q;
  assign bus.tgt_sel   = sel_q;
  assign bus.tgt_we    = we_q;
  assign bus.tgt_addr  = addr_q;
  assign bus.tgt_wdata = wdata_q;
  assign bus.tgt_be    = be_q;

endmodule
